// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers the four digits shown on a multiplexed, active-low
// 7-segment display by watching its anode and segment lines.
// Optional build macro DP_CAPTURE_EN: when defined, the decimal point of each
// digit is synchronized and captured into dp_mask; otherwise dp_mask stays 0.
module seg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp_n,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_mask,
  output logic       frame_strobe,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       scan_lost
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SettleMax   = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SettleLast  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  // Returns {err, value}; blank decodes to E without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h7F:   r = 5'h0E;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [3:0]    an_s1_q, an_s2_q, an_prev_q;
  logic [6:0]    seg_s1_q, seg_s2_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    captured_q, captured_d;
  logic [3:0]    digit_q [4];
  logic [3:0]    digit_d [4];
  logic          strobe_q, strobe_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          lost_q, lost_d;

  logic [3:0] an_sel;
  logic       an_ok, an_chg, cap_fire, to_hit, frame_done;
  logic [3:0] cap_mask;
  logic [4:0] seg_dec;

  // Anode qualification and capture strobe derived from synchronized inputs.
  always_comb begin
    an_sel   = ~an_s2_q;
    an_ok    = (an_sel != 4'd0) && ((an_sel & (an_sel - 4'd1)) == 4'd0);
    an_chg   = (an_s2_q != an_prev_q);
    // Fires once per dwell, on the step where the settle counter reaches its limit.
    cap_fire = !an_chg && an_ok && (settle_q == SettleLast);
    cap_mask = cap_fire ? an_sel : 4'd0;
    seg_dec  = decode_seg(seg_s2_q);
  end

  // Next-state for counters, capture bookkeeping and status flags.
  always_comb begin
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    captured_d = captured_q;
    strobe_d   = 1'b0;
    valid_d    = valid_q;
    err_d      = 1'b0;
    lost_d     = lost_q;
    for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];

    if (an_chg) begin
      settle_d = '0;
      tmo_d    = '0;
    end else begin
      if (an_ok && (settle_q != SettleMax)) settle_d = settle_q + SW'(1);
      if (tmo_q != TimeoutLast) tmo_d = tmo_q + TW'(1);
    end
    to_hit = (tmo_d == TimeoutLast);

    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i]) digit_d[i] = seg_dec[3:0];
    end
    err_d = cap_fire && seg_dec[4];

    // A completed frame is acknowledged one cycle after the last capture.
    frame_done = (captured_q == 4'hF);
    captured_d = (frame_done ? 4'd0 : captured_q) | cap_mask;
    if (frame_done) valid_d = 1'b1;
    strobe_d = frame_done && !to_hit;

    if (an_chg && an_ok) lost_d = 1'b0;
    if (to_hit) begin
      lost_d     = 1'b1;
      valid_d    = 1'b0;
      captured_d = 4'd0;
    end
  end

  // Synchronizers and all state registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1_q    <= 4'hF;
      an_s2_q    <= 4'hF;
      an_prev_q  <= 4'hF;
      seg_s1_q   <= 7'h7F;
      seg_s2_q   <= 7'h7F;
      settle_q   <= '0;
      tmo_q      <= '0;
      captured_q <= 4'd0;
      strobe_q   <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lost_q     <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'hE;
    end else begin
      an_s1_q    <= an;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      seg_s1_q   <= seg;
      seg_s2_q   <= seg_s1_q;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      captured_q <= captured_d;
      strobe_q   <= strobe_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lost_q     <= lost_d;
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign digit0       = digit_q[0];
  assign digit1       = digit_q[1];
  assign digit2       = digit_q[2];
  assign digit3       = digit_q[3];
  assign frame_strobe = strobe_q;
  assign frame_valid  = valid_q;
  assign seg_err      = err_q;
  assign scan_lost    = lost_q;

`ifdef DP_CAPTURE_EN
  logic       dp_s1_q, dp_s2_q;
  logic [3:0] dp_mask_q, dp_mask_d;

  // Decimal point of the captured digit is stored as lit-high.
  always_comb begin
    dp_mask_d = dp_mask_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask[i]) dp_mask_d[i] = ~dp_s2_q;
    end
  end

  // Decimal-point synchronizer and captured mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_s1_q   <= 1'b1;
      dp_s2_q   <= 1'b1;
      dp_mask_q <= 4'd0;
    end else begin
      dp_s1_q   <= dp_n;
      dp_s2_q   <= dp_s1_q;
      dp_mask_q <= dp_mask_d;
    end
  end

  assign dp_mask = dp_mask_q;
`else
  logic unused_dp_n;
  assign unused_dp_n = dp_n;
  assign dp_mask     = 4'd0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed, table-driven bench for seg_scan_capture (SETTLE=16, TIMEOUT=200).
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic [3:0] digit0, digit1, digit2, digit3, dp_mask;
  logic       frame_strobe, frame_valid, seg_err, scan_lost;

  int total = 0;
  int bad   = 0;
  int n_err = 0;
  int n_frm = 0;

  seg_scan_capture #(
    .SETTLE_CYCLES (16),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .dp_n        (dp_n),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .dp_mask     (dp_mask),
    .frame_strobe(frame_strobe),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .scan_lost   (scan_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    int         idx;
    logic [3:0] val;
    int         errs;
    int         frames;
    logic       fv;
    logic [3:0] dp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (seg_err) n_err++;
    if (frame_strobe) n_frm++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input logic d, input int cyc);
    an   = a;
    seg  = s;
    dp_n = d;
    repeat (cyc) tick();
  endtask

  function automatic logic [3:0] dig(input int i);
    case (i)
      0:       return digit0;
      1:       return digit1;
      2:       return digit2;
      default: return digit3;
    endcase
  endfunction

  initial begin
    int         err0;
    int         lat;
    logic [3:0] exp_dp;

    vecs[0]  = '{4'b0111, 7'h79, 1'b1, 3, 4'h1, 0, 0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b1011, 7'h24, 1'b0, 2, 4'h2, 0, 0, 1'b0, 4'b0100};
    vecs[2]  = '{4'b1101, 7'h30, 1'b1, 1, 4'h3, 0, 0, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1110, 7'h19, 1'b1, 0, 4'h4, 0, 1, 1'b1, 4'b0100};
    vecs[4]  = '{4'b0111, 7'h7E, 1'b1, 3, 4'hF, 1, 1, 1'b1, 4'b0100};
    vecs[5]  = '{4'b1011, 7'h7F, 1'b0, 2, 4'hE, 0, 1, 1'b1, 4'b0100};
    vecs[6]  = '{4'b1101, 7'h40, 1'b1, 1, 4'h0, 0, 1, 1'b1, 4'b0100};
    vecs[7]  = '{4'b1110, 7'h10, 1'b1, 0, 4'h9, 0, 2, 1'b1, 4'b0100};
    vecs[8]  = '{4'b0111, 7'h02, 1'b1, 3, 4'h6, 0, 2, 1'b1, 4'b0100};
    vecs[9]  = '{4'b1011, 7'h00, 1'b0, 2, 4'h8, 0, 2, 1'b1, 4'b0100};
    vecs[10] = '{4'b1101, 7'h12, 1'b1, 1, 4'h5, 0, 2, 1'b1, 4'b0100};
    vecs[11] = '{4'b1110, 7'h78, 1'b1, 0, 4'h7, 0, 3, 1'b1, 4'b0100};

    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    dp_n  = 1'b1;
    repeat (3) tick();
    check("rst_digits", {digit3, digit2, digit1, digit0}, 16'hEEEE);
    check("rst_flags", {dp_mask, frame_strobe, frame_valid, seg_err, scan_lost}, 8'h00);
    reset = 1'b0;
    tick();

    // Full-length dwells: every row captures one digit.
    for (int i = 0; i < 12; i++) begin
      err0 = n_err;
      dwell(vecs[i].an, vecs[i].seg, vecs[i].dp_n, 40);
`ifdef DP_CAPTURE_EN
      exp_dp = vecs[i].dp;
`else
      exp_dp = 4'b0000;
`endif
      check($sformatf("row%0d_digit", i), dig(vecs[i].idx), vecs[i].val);
      check($sformatf("row%0d_seg_err", i), n_err - err0, vecs[i].errs);
      check($sformatf("row%0d_frames", i), n_frm, vecs[i].frames);
      check($sformatf("row%0d_valid", i), frame_valid, vecs[i].fv);
      check($sformatf("row%0d_dp_mask", i), dp_mask, exp_dp);
      if (i == 3) check("frame1_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
    end

    // Dwells shorter than the settle time capture nothing.
    err0 = n_err;
    dwell(4'b0111, 7'h40, 1'b1, 10);
    dwell(4'b1011, 7'h40, 1'b1, 10);
    dwell(4'b1101, 7'h40, 1'b1, 10);
    dwell(4'b1110, 7'h40, 1'b1, 10);
    check("short_digits", {digit3, digit2, digit1, digit0}, 16'h6857);
    check("short_frames", n_frm, 3);

    // Two anodes low is idle.
    dwell(4'b1001, 7'h40, 1'b1, 100);
    check("idle_digits", {digit3, digit2, digit1, digit0}, 16'h6857);
    check("idle_frames", n_frm, 3);
    check("idle_seg_err", n_err - err0, 0);
    check("idle_flags", {frame_valid, scan_lost}, 2'b10);

    // Input change to digit update latency: 2 + 16 + 1 clocks.
    an  = 4'b1110;
    seg = 7'h79;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (lat == 0 && digit0 == 4'h1) lat = k;
    end
    check("latency", lat, 19);

    // Hold anode past the timeout.
    repeat (200) tick();
    check("timeout_lost", scan_lost, 1'b1);
    check("timeout_valid", frame_valid, 1'b0);
    an  = 4'b0111;
    seg = 7'h79;
    repeat (2) tick();
    check("lost_before_detect", scan_lost, 1'b1);
    tick();
    check("lost_cleared", scan_lost, 1'b0);
    repeat (37) tick();
    check("post_lost_digit3", digit3, 4'h1);
    // Timeout must have discarded the earlier digit0 capture.
    dwell(4'b1011, 7'h24, 1'b1, 40);
    dwell(4'b1101, 7'h30, 1'b1, 40);
    check("partial_frames", n_frm, 3);
    check("partial_valid", frame_valid, 1'b0);
    dwell(4'b1110, 7'h19, 1'b1, 40);
    check("refill_frames", n_frm, 4);
    check("refill_valid", frame_valid, 1'b1);

    // Reset mid-dwell aborts the pending capture.
    dwell(4'b1101, 7'h19, 1'b1, 10);
    reset = 1'b1;
    repeat (2) tick();
    check("midrst_digits", {digit3, digit2, digit1, digit0}, 16'hEEEE);
    check("midrst_flags", {dp_mask, frame_strobe, frame_valid, seg_err, scan_lost}, 8'h00);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("abort_digit1", digit1, 4'hE);
    check("abort_frames", n_frm, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive stable synchronized-anode cycles required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: cycles without an anode change before scan_lost is raised; SHALL be greater than SETTLE_CYCLES.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 an  input  4  active-low anode enables of the scanned display; an[i] low selects digit i.
REQ-006 seg  input  7  active-low segments {g,f,e,d,c,b,a}.
REQ-007 dp_n  input  1  active-low decimal point.
REQ-008 digit0, digit1, digit2, digit3  output  4 each  decoded value of the corresponding digit.
REQ-009 dp_mask  output  4  captured decimal-point state per digit; 1 means lit.
REQ-010 frame_strobe  output  1  one-cycle pulse when all four digits have been captured.
REQ-011 frame_valid  output  1  high after the first complete frame, until timeout or reset.
REQ-012 seg_err  output  1  one-cycle pulse on capture of a non-decimal, non-blank pattern.
REQ-013 scan_lost  output  1  high while the scan is considered stopped.

Function
REQ-014 an, seg and dp_n SHALL each pass through a two-flop synchronizer; all further logic uses synchronized values only.
REQ-015 A synchronized anode value is valid only when exactly one bit is 0; all other values are idle and are never captured.
REQ-016 A change of the synchronized anode value SHALL clear the settle counter and the timeout counter.
REQ-017 While the anode is valid and unchanged, the settle counter SHALL increment, saturating at SETTLE_CYCLES.
REQ-018 Capture for digit i SHALL occur on the cycle the settle counter reaches SETTLE_CYCLES, exactly once per anode dwell.
REQ-019 Capture decode SHALL be: 0x40 to 0, 0x79 to 1, 0x24 to 2, 0x30 to 3, 0x19 to 4, 0x12 to 5, 0x02 to 6, 0x78 to 7, 0x00 to 8, 0x10 to 9.
REQ-020 Blank pattern 0x7F SHALL decode to 4'hE with no seg_err; every other pattern SHALL decode to 4'hF with a seg_err pulse on the cycle after capture.
REQ-021 Each capture SHALL set captured bit i; recapturing digit i before frame completion overwrites digit i and leaves the bit set.
REQ-022 When all four captured bits are set, frame_strobe SHALL pulse on the following cycle, frame_valid SHALL be set, and the captured bits SHALL clear in that same cycle.
REQ-023 Digit and dp_mask outputs SHALL update on capture, independently of frame completion.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL set scan_lost, clear frame_valid and clear the captured bits; the counter saturates there.
REQ-025 The next anode change to a valid value SHALL clear scan_lost in the same cycle the change is detected.
REQ-026 Latency from an input change to the digit output update SHALL be 2 sync cycles plus SETTLE_CYCLES plus 1.

Reset
REQ-027 While reset is high, all outputs SHALL be held at their reset values: digit0..3 = 4'hE, dp_mask = 0, frame_strobe = 0, frame_valid = 0, seg_err = 0, scan_lost = 0.
REQ-028 Reset SHALL clear the synchronizers to an = 4'hF, seg = 7'h7F and dp_n = 1, and SHALL clear all counters and captured bits.
REQ-029 Reset asserted mid-dwell SHALL abort the pending capture.
REQ-030 After reset release, capture of the current digit SHALL begin only after a fresh anode change.

Configuration
REQ-031 Macro DP_CAPTURE_EN: when defined, dp_n is synchronized and ~dp_n is stored into dp_mask[i] on capture.
REQ-032 When DP_CAPTURE_EN is undefined, dp_n SHALL be ignored, its synchronizer omitted, and dp_mask held at 0.

Verification
REQ-033 Scan the an sequence 0111, 1011, 1101, 1110 with seg 0x79, 0x24, 0x30, 0x19 and 40-cycle dwells -> one frame_strobe pulse; digit3..0 read as 1, 2, 3, 4; frame_valid = 1.
REQ-034 Apply seg = 0x7E on one dwell -> that digit reads 4'hF and exactly one seg_err pulse occurs; seg = 0x7F -> reads 4'hE with no seg_err.
REQ-035 With a dwell of 10 cycles and SETTLE_CYCLES = 16 -> no capture and no frame_strobe.
REQ-036 Apply an = 1001 (two digits selected) for 100 cycles -> no capture; outputs unchanged.
REQ-037 Hold an constant past TIMEOUT_CYCLES (set to 200 for test) -> scan_lost = 1 and frame_valid = 0; a subsequent valid anode change clears scan_lost.
REQ-038 With DP_CAPTURE_EN defined, dp_n = 0 on digit 2 only -> dp_mask = 4'b0100; with the macro undefined -> dp_mask = 0.
